// File: rtl/sd_resp_receiver.sv
// ---------------------------------------------------------------------------
// sd_resp_receiver
//   Samples the SD CMD line on rising edges of the slow SD clock (oversampled
//   by CLOCK_50). It finds the response start bit, shifts in a fixed-length
//   response, and checks the framing and, optionally, the CRC7.
//
//   Optional feature: define SD_RESP_CRC_CHECK_EN to add the serial CRC7
//   check (x^7+x^3+1, init 0) over the first RESP_BITS-8 bits. Without it,
//   crc_ok reports framing only.
//
// Ports
//   CLOCK_50        in   system clock (only clock of the block)
//   reset_n         in   synchronous active-low reset
//   sd_clk_in       in   SD clock, asynchronous to CLOCK_50
//   sd_cmd_in       in   SD CMD line, card-to-host direction
//   arm             in   pulse: command sent, start hunting for the start bit
//   response_signal out  live 16-bit window, bit 0 = newest bit
//   resp_data       out  latched response, first-received bit at MSB
//   resp_valid      out  one-cycle pulse, response complete
//   resp_timeout    out  one-cycle pulse, no start bit within TIMEOUT_EDGES
//   crc_ok          out  qualifies resp_data, held until the next resp_valid
//   busy            out  high while WAIT_START / RECEIVE / DONE
// ---------------------------------------------------------------------------
module sd_resp_receiver #(
  parameter int unsigned RESP_BITS     = 48,
  parameter int unsigned TIMEOUT_EDGES = 64,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 sd_clk_in,
  input  logic                 sd_cmd_in,
  input  logic                 arm,
  output logic [15:0]          response_signal,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  output logic                 resp_timeout,
  output logic                 crc_ok,
  output logic                 busy
);

  localparam int unsigned BIT_CNT_W  = $clog2(RESP_BITS + 1);
  localparam int unsigned EDGE_CNT_W = $clog2(TIMEOUT_EDGES + 1);
  localparam int unsigned CRC_BITS   = RESP_BITS - 8;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_RECEIVE    = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_cmd_sync;
  logic                   r_clk_prev;
  logic                   r_strobe;
  logic                   r_bit;

  state_t                 r_state;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [EDGE_CNT_W-1:0]  r_edge_cnt;
  logic [RESP_BITS-1:0]   r_shift;
  logic [RESP_BITS-1:0]   r_resp_data;
  logic                   r_resp_valid;
  logic                   r_resp_timeout;
  logic                   r_crc_ok;
  logic                   r_busy;

  logic                   w_clk_s;
  logic                   w_cmd_s;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_nxt;
  logic [EDGE_CNT_W-1:0]  w_edge_cnt_nxt;
  logic                   w_frame_ok;
  logic                   w_check_ok;

  assign w_clk_s        = r_clk_sync[SYNC_STAGES-1];
  assign w_cmd_s        = r_cmd_sync[SYNC_STAGES-1];
  assign w_bit_cnt_nxt  = r_bit_cnt + BIT_CNT_W'(1);
  assign w_edge_cnt_nxt = r_edge_cnt + EDGE_CNT_W'(1);
  // Transmission bit must be 0 and end bit must be 1.
  assign w_frame_ok     = ~r_shift[RESP_BITS-2] & r_shift[0];

`ifdef SD_RESP_CRC_CHECK_EN
  logic [6:0] r_crc;

  // One serial CRC7 step, MSB-first, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign w_check_ok = w_frame_ok & (r_crc == r_shift[7:1]);
`else
  assign w_check_ok = w_frame_ok;
`endif

  // Synchronisers: equal depth keeps the clk and cmd samples aligned.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_clk_sync <= '0;
      r_cmd_sync <= '0;
      r_clk_prev <= 1'b0;
      r_strobe   <= 1'b0;
      r_bit      <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sd_clk_in};
      r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], sd_cmd_in};
      r_clk_prev <= w_clk_s;
      // Registered rising-edge strobe; the cmd bit is captured alongside it.
      r_strobe   <= w_clk_s & ~r_clk_prev;
      r_bit      <= w_cmd_s;
    end
  end

  // Receive FSM with registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_bit_cnt      <= '0;
      r_edge_cnt     <= '0;
      r_shift        <= '0;
      r_resp_data    <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_crc_ok       <= 1'b0;
      r_busy         <= 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
      r_crc          <= '0;
`endif
    end else begin
      r_resp_valid   <= 1'b0;
      r_resp_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          // A strobe coinciding with arm is deliberately not sampled.
          if (arm) begin
            r_state    <= S_WAIT_START;
            r_bit_cnt  <= '0;
            r_edge_cnt <= '0;
            r_shift    <= '0;
            r_busy     <= 1'b1;
`ifdef SD_RESP_CRC_CHECK_EN
            r_crc      <= '0;
`endif
          end
        end

        S_WAIT_START: begin
          if (r_strobe) begin
            r_shift <= {r_shift[RESP_BITS-2:0], r_bit};
            if (!r_bit) begin
              r_bit_cnt <= BIT_CNT_W'(1);
              r_state   <= S_RECEIVE;
`ifdef SD_RESP_CRC_CHECK_EN
              r_crc     <= f_crc7_step(r_crc, 1'b0);
`endif
            end else begin
              r_edge_cnt <= w_edge_cnt_nxt;
              if (w_edge_cnt_nxt == EDGE_CNT_W'(TIMEOUT_EDGES)) begin
                r_resp_timeout <= 1'b1;
                r_busy         <= 1'b0;
                r_state        <= S_IDLE;
              end
            end
          end
        end

        S_RECEIVE: begin
          if (r_strobe) begin
            r_shift   <= {r_shift[RESP_BITS-2:0], r_bit};
            r_bit_cnt <= w_bit_cnt_nxt;
`ifdef SD_RESP_CRC_CHECK_EN
            // r_bit_cnt is the index of the incoming bit.
            if (r_bit_cnt < BIT_CNT_W'(CRC_BITS)) begin
              r_crc <= f_crc7_step(r_crc, r_bit);
            end
`endif
            if (w_bit_cnt_nxt == BIT_CNT_W'(RESP_BITS)) begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_resp_data  <= r_shift;
          r_crc_ok     <= w_check_ok;
          r_resp_valid <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign response_signal = r_shift[15:0];
  assign resp_data       = r_resp_data;
  assign resp_valid      = r_resp_valid;
  assign resp_timeout    = r_resp_timeout;
  assign crc_ok          = r_crc_ok;
  assign busy            = r_busy;

endmodule

// File: tb/tb_sd_resp_receiver.sv
// ---------------------------------------------------------------------------
// tb_sd_resp_receiver
//   Randomised and directed response frames for sd_resp_receiver, checked
//   against a reference built from frame-level rules (polynomial division
//   CRC7, framing bits, fixed pipeline latencies from the sync depth).
//   The SD clock is scaled down to 20 CLOCK_50 cycles per bit to keep
//   the run short.
// ---------------------------------------------------------------------------
module tb_sd_resp_receiver;

  localparam int unsigned RESP_BITS     = 48;
  localparam int unsigned TIMEOUT_EDGES = 64;
  localparam int unsigned SYNC_STAGES   = 2;
  localparam int          HALF          = 10;

  logic                 CLOCK_50;
  logic                 reset_n;
  logic                 sd_clk_in;
  logic                 sd_cmd_in;
  logic                 arm;
  logic [15:0]          response_signal;
  logic [RESP_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_timeout;
  logic                 crc_ok;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int rise_cyc = 0;
  int valid_cnt = 0;
  int to_cnt = 0;
  int valid_lat = 0;
  int to_lat = 0;
  logic [47:0] cap_data = '0;
  logic        cap_crc = 1'b0;

  sd_resp_receiver #(
    .RESP_BITS    (RESP_BITS),
    .TIMEOUT_EDGES(TIMEOUT_EDGES),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .sd_clk_in      (sd_clk_in),
    .sd_cmd_in      (sd_cmd_in),
    .arm            (arm),
    .response_signal(response_signal),
    .resp_data      (resp_data),
    .resp_valid     (resp_valid),
    .resp_timeout   (resp_timeout),
    .crc_ok         (crc_ok),
    .busy           (busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Pulse monitor, sampled just after each active edge.
  always @(posedge CLOCK_50) begin
    #1;
    cyc = cyc + 1;
    if (resp_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_lat = cyc - rise_cyc;
      cap_data  = resp_data;
      cap_crc   = crc_ok;
    end
    if (resp_timeout) begin
      to_cnt = to_cnt + 1;
      to_lat = cyc - rise_cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r = r ^ (47'(8'h89) << (i - 7));
    end
    return r[6:0];
  endfunction

  function automatic logic exp_ok(input logic [47:0] d);
    logic ok;
    ok = ~d[46] & d[0];
`ifdef SD_RESP_CRC_CHECK_EN
    ok = ok & (ref_crc7(d[47:8]) == d[7:1]);
`endif
    return ok;
  endfunction

  // One SD clock period: cmd changes while clk is low, sampled on the rise.
  task automatic sd_bit(input logic b);
    @(negedge CLOCK_50);
    sd_clk_in = 1'b0;
    sd_cmd_in = b;
    repeat (HALF) @(negedge CLOCK_50);
    sd_clk_in = 1'b1;
    rise_cyc  = cyc;
    repeat (HALF - 1) @(negedge CLOCK_50);
  endtask

  task automatic pulse_arm();
    @(negedge CLOCK_50);
    arm = 1'b1;
    @(negedge CLOCK_50);
    arm = 1'b0;
  endtask

  task automatic run_frame(input logic [47:0] d, input int idle, input int arm_at, input string name);
    int v0;
    int t0;
    v0 = valid_cnt;
    t0 = to_cnt;
    pulse_arm();
    check({name, "_busy_armed"}, 64'(busy), 64'd1);
    repeat (idle) sd_bit(1'b1);
    for (int i = 0; i < 48; i++) begin
      sd_bit(d[47 - i]);
      if (i == 15) check({name, "_win16"}, 64'(response_signal), 64'(d[47:32]));
      if (i == arm_at) pulse_arm();
    end
    repeat (4) @(negedge CLOCK_50);
    check({name, "_valid_cnt"}, 64'(valid_cnt - v0), 64'd1);
    check({name, "_data"}, 64'(cap_data), 64'(d));
    check({name, "_crc_ok"}, 64'(crc_ok), 64'(exp_ok(d)));
    check({name, "_window"}, 64'(response_signal), 64'(d[15:0]));
    check({name, "_latency"}, 64'(valid_lat), 64'(SYNC_STAGES + 3));
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_no_timeout"}, 64'(to_cnt - t0), 64'd0);
  endtask

  initial begin
    logic [47:0] d;
    logic [39:0] m;
    logic [6:0]  c;
    logic        e;
    int          v0;
    int          t0;

    reset_n   = 1'b0;
    sd_clk_in = 1'b0;
    sd_cmd_in = 1'b1;
    arm       = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("rst_window", 64'(response_signal), 64'd0);
    check("rst_data", 64'(resp_data), 64'd0);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_timeout", 64'(resp_timeout), 64'd0);
    check("rst_crc_ok", 64'(crc_ok), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    run_frame(48'h08000001AA13, 3, -1, "nominal");
    run_frame(48'h08000001AA15, 3, -1, "crc_err");
    run_frame(48'h08000001AA12, 3, -1, "frame_err");

    // Timeout: 63 high edges keep hunting, the 64th ends it.
    v0 = valid_cnt;
    t0 = to_cnt;
    pulse_arm();
    repeat (TIMEOUT_EDGES - 1) sd_bit(1'b1);
    check("to_not_yet", 64'(to_cnt - t0), 64'd0);
    check("to_busy_hold", 64'(busy), 64'd1);
    sd_bit(1'b1);
    check("to_pulse", 64'(to_cnt - t0), 64'd1);
    check("to_latency", 64'(to_lat), 64'(SYNC_STAGES + 2));
    check("to_busy_fall", 64'(busy), 64'd0);
    check("to_no_valid", 64'(valid_cnt - v0), 64'd0);

    // Reset mid-frame abandons it silently; unarmed bits are then ignored.
    d  = 48'h08000001AA13;
    v0 = valid_cnt;
    pulse_arm();
    for (int i = 0; i < 20; i++) sd_bit(d[47 - i]);
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("mrst_window", 64'(response_signal), 64'd0);
    check("mrst_data", 64'(resp_data), 64'd0);
    check("mrst_crc_ok", 64'(crc_ok), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    for (int i = 20; i < 48; i++) sd_bit(d[47 - i]);
    repeat (4) @(negedge CLOCK_50);
    check("mrst_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("mrst_idle", 64'(busy), 64'd0);

    // Arm while busy is ignored.
    run_frame(48'h08000001AA13, 2, 20, "midarm");

    // Random frames: mostly valid CRC/framing, some corrupted.
    for (int k = 0; k < 8; k++) begin
      m = {1'b0, ($urandom_range(0, 3) == 0), 38'({$urandom, $urandom})};
      c = ref_crc7(m);
      if ($urandom_range(0, 2) == 0) c = c ^ 7'($urandom_range(1, 127));
      e = ($urandom_range(0, 4) != 0);
      d = {m, c, e};
      run_frame(d, int'($urandom_range(0, 5)), -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
